ps2_key_tracker: RTL and testbench

Parametrised scan-code set-2 interpreter. Sits downstream of the PS/2 byte receiver and consumes its raw byte stream.
Handles E0, F0 and E1 prefix sequences. Maintains a held-key bitmap for a configurable key table and queues every make/break event into a first-word-fall-through (FWFT) event FIFO for the game/UI logic.
Replaces fixed 24-key decoding with run-time-agnostic, width/depth-parametrised tracking plus event buffering.

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_key_tracker_if.sv | 23 ++
 rtl/ps2_evt_fifo.sv | 72 +++++++
 rtl/ps2_key_tracker.sv | 180 ++++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, parser states and event field layout for the PS/2 set-2 key tracker.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BRK        = 8'hF0;
    localparam logic [7:0] PS2_PAUSE      = 8'hE1;
    localparam logic [7:0] PS2_BAT        = 8'hAA;
    localparam logic [7:0] PS2_ACK        = 8'hFA;
    localparam logic [7:0] PS2_FAKE_SHIFT = 8'h12;
    localparam logic [7:0] PS2_RESEND     = 8'hFE;
    localparam logic [7:0] PS2_ECHO       = 8'hEE;
    localparam logic [7:0] PS2_OVR_LO     = 8'h00;
    localparam logic [7:0] PS2_OVR_HI     = 8'hFF;

    typedef enum logic [2:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk,
        StSkip
    } ps2_state_e;

    // Event word: {mapped, brk, ext, code[7:0]}
    localparam int unsigned EVT_W          = 11;
    localparam int unsigned EVT_CODE_LSB   = 0;
    localparam int unsigned EVT_EXT_BIT    = 8;
    localparam int unsigned EVT_BRK_BIT    = 9;
    localparam int unsigned EVT_MAPPED_BIT = 10;
    localparam int unsigned EVT_IDX_W      = 5;
    localparam int unsigned EVT_CNT_W      = 7;

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Byte-in / event-out bus of the key tracker; master is the tracker, slave the byte source/consumer.
interface ps2_key_tracker_if;
    import ps2_pkg::*;

    logic                 byte_valid;
    logic [7:0]           byte_data;
    logic                 evt_valid;
    logic [EVT_W-1:0]     evt_data;
    logic [EVT_IDX_W-1:0] evt_index;
    logic                 evt_ready;
    logic [EVT_CNT_W-1:0] evt_count;

    modport master (
        input  byte_valid, byte_data, evt_ready,
        output evt_valid, evt_data, evt_index, evt_count
    );

    modport slave (
        output byte_valid, byte_data, evt_ready,
        input  evt_valid, evt_data, evt_index, evt_count
    );

endinterface

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO with occupancy count; Depth must be a power of two.
module ps2_evt_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 16,
    parameter int unsigned CntW  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic             full_o,
    output logic [Width-1:0] data_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             empty, pop_ok, push_ok;

    assign empty   = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign valid_o = !empty;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
    assign pop_ok  = pop_i && !empty;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Scan-code set-2 interpreter: held-key bitmap plus buffered make/break events.
// Define TYPEMATIC_FILTER_EN to suppress repeat makes of keys already held.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int unsigned               NUM_KEYS   = 8,
    parameter logic [NUM_KEYS*9-1:0]     KEY_MAP    = {9'h172, 9'h175, 9'h029, 9'h05A,
                                                       9'h026, 9'h01E, 9'h016, 9'h045},
    parameter int unsigned               FIFO_DEPTH = 8,
    parameter int unsigned               PAUSE_SKIP = 7
) (
    input  logic                clk,
    input  logic                rst,
    ps2_key_tracker_if.master   bus_io,
    output logic [NUM_KEYS-1:0] key_down,
    output logic                any_down,
    output logic                overflow,
    input  logic                clr_ovf
);

    ps2_state_e           state_q, state_d;
    logic [7:0]           skip_q, skip_d;
    logic [NUM_KEYS-1:0]  key_down_q, key_down_d;
    logic                 overflow_q, overflow_d;

    logic [7:0]           b;
    logic                 ev_fire, ev_brk, ev_ext, bat_clr;
    logic                 lk_hit;
    logic [EVT_IDX_W-1:0] lk_idx;
    logic [NUM_KEYS-1:0]  lk_oh;
    logic                 push, fifo_full, drop;
    logic [EVT_W-1:0]     ev_data;
    logic [EVT_IDX_W+EVT_W-1:0] head;

    assign b = bus_io.byte_data;

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        ev_fire = 1'b0;
        ev_brk  = 1'b0;
        ev_ext  = 1'b0;
        bat_clr = 1'b0;
        if (bus_io.byte_valid) begin
            unique case (state_q)
                StIdle: begin
                    case (b)
                        PS2_EXT:   state_d = StExt;
                        PS2_BRK:   state_d = StBrk;
                        PS2_PAUSE: begin
                            state_d = StSkip;
                            skip_d  = 8'(PAUSE_SKIP);
                        end
                        PS2_BAT:   bat_clr = 1'b1;
                        PS2_ACK, PS2_RESEND, PS2_ECHO, PS2_OVR_LO, PS2_OVR_HI: begin
                        end
                        default:   ev_fire = 1'b1;
                    endcase
                end
                StExt: begin
                    if (b == PS2_BRK) begin
                        state_d = StExtBrk;
                    end else begin
                        state_d = StIdle;
                        ev_fire = (b != PS2_FAKE_SHIFT);
                        ev_ext  = 1'b1;
                    end
                end
                StBrk: begin
                    state_d = StIdle;
                    ev_fire = 1'b1;
                    ev_brk  = 1'b1;
                end
                StExtBrk: begin
                    state_d = StIdle;
                    ev_fire = (b != PS2_FAKE_SHIFT);
                    ev_brk  = 1'b1;
                    ev_ext  = 1'b1;
                end
                StSkip: begin
                    if (skip_q <= 8'd1) begin
                        state_d = StIdle;
                        skip_d  = '0;
                    end else begin
                        skip_d = skip_q - 8'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Lowest matching table index wins.
    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        lk_oh  = '0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            if (!lk_hit && KEY_MAP[9*i +: 9] == {ev_ext, b}) begin
                lk_hit   = 1'b1;
                lk_idx   = EVT_IDX_W'(i);
                lk_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        key_down_d = key_down_q;
        push       = ev_fire;
        if (bat_clr) begin
            key_down_d = '0;
        end
        if (ev_fire && lk_hit) begin
            if (ev_brk) begin
                key_down_d = key_down_q & ~lk_oh;
            end else begin
                key_down_d = key_down_q | lk_oh;
            end
`ifdef TYPEMATIC_FILTER_EN
            if (!ev_brk && |(key_down_q & lk_oh)) begin
                push = 1'b0;
            end
`endif
        end
        ev_data                       = '0;
        ev_data[EVT_CODE_LSB +: 8]    = b;
        ev_data[EVT_EXT_BIT]          = ev_ext;
        ev_data[EVT_BRK_BIT]          = ev_brk;
        ev_data[EVT_MAPPED_BIT]       = lk_hit;
    end

    // A full FIFO only drops when nothing is popped in the same cycle; set beats clear.
    assign drop = push && fifo_full && !bus_io.evt_ready;

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            skip_q     <= '0;
            key_down_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            key_down_q <= key_down_d;
            overflow_q <= overflow_d;
        end
    end

    ps2_evt_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (EVT_IDX_W + EVT_W),
        .CntW  (EVT_CNT_W)
    ) u_evt_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  ({lk_idx, ev_data}),
        .pop_i   (bus_io.evt_ready),
        .valid_o (bus_io.evt_valid),
        .full_o  (fifo_full),
        .data_o  (head),
        .count_o (bus_io.evt_count)
    );

    assign bus_io.evt_data  = head[EVT_W-1:0];
    assign bus_io.evt_index = head[EVT_IDX_W+EVT_W-1:EVT_W];
    assign key_down         = key_down_q;
    assign any_down         = |key_down_q;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed plus random bench for ps2_key_tracker against a prefix-flag / queue reference model.
// Honours TYPEMATIC_FILTER_EN to match the build under test.
module tb_ps2_key_tracker;

    localparam int DEPTH = 8;
    localparam int SKIP  = 7;
    localparam logic [8:0] KMAP [8] = '{9'h045, 9'h016, 9'h01E, 9'h026,
                                       9'h05A, 9'h029, 9'h175, 9'h172};

    logic       clk;
    logic       rst;
    logic [7:0] key_down;
    logic       any_down;
    logic       overflow;
    logic       clr_ovf;

    ps2_key_tracker_if bus ();

    ps2_key_tracker dut (
        .clk      (clk),
        .rst      (rst),
        .bus_io   (bus),
        .key_down (key_down),
        .any_down (any_down),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: pending-prefix flags, skip budget, held keys, event queue {index, event}.
    bit          m_e0, m_f0;
    int          m_skip;
    logic [7:0]  m_keys;
    bit          m_ovf;
    logic [15:0] mq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_e0 = 0;
        m_f0 = 0;
        m_skip = 0;
        m_keys = '0;
        m_ovf = 0;
        mq.delete();
    endtask

    task automatic emit(input bit brk, input bit ext, input logic [7:0] code,
                        output bit ev, output logic [15:0] ent);
        int idx;
        idx = -1;
        for (int i = 0; i < 8; i++) begin
            if (idx < 0 && KMAP[i] == {ext, code}) idx = i;
        end
        ev = 1;
        if (idx >= 0) begin
`ifdef TYPEMATIC_FILTER_EN
            if (!brk && m_keys[idx]) ev = 0;
`endif
            m_keys[idx] = !brk;
        end
        ent = {(idx >= 0) ? 5'(idx) : 5'd0, idx >= 0, brk, ext, code};
    endtask

    task automatic model_byte(input logic [7:0] b, output bit ev, output logic [15:0] ent);
        ev = 0;
        ent = '0;
        if (m_skip > 0) begin
            m_skip--;
        end else if (!m_e0 && !m_f0) begin
            case (b)
                8'hE0: m_e0 = 1;
                8'hF0: m_f0 = 1;
                8'hE1: m_skip = SKIP;
                8'hAA: m_keys = '0;
                8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin end
                default: emit(0, 0, b, ev, ent);
            endcase
        end else if (!m_f0) begin
            if (b == 8'hF0) begin
                m_f0 = 1;
            end else begin
                m_e0 = 0;
                if (b != 8'h12) emit(0, 1, b, ev, ent);
            end
        end else begin
            if (!(m_e0 && b == 8'h12)) emit(1, m_e0, b, ev, ent);
            m_e0 = 0;
            m_f0 = 0;
        end
    endtask

    task automatic check_all();
        chk("key_down", key_down, m_keys);
        chk("any_down", any_down, |m_keys);
        chk("evt_count", bus.evt_count, mq.size());
        chk("evt_valid", bus.evt_valid, mq.size() != 0);
        chk("overflow", overflow, m_ovf);
        if (mq.size() > 0) begin
            chk("evt_data", bus.evt_data, mq[0][10:0]);
            chk("evt_index", bus.evt_index, mq[0][15:11]);
        end
    endtask

    // One clock: drive at negedge, update model, check 1 time unit after the posedge.
    task automatic step(input bit v, input logic [7:0] d, input bit rdy, input bit clr);
        bit          do_pop, ev, room;
        logic [15:0] ent;
        int          sz;
        @(negedge clk);
        bus.byte_valid = v;
        bus.byte_data  = d;
        bus.evt_ready  = rdy;
        clr_ovf        = clr;
        sz = mq.size();
        do_pop = rdy && (sz > 0);
        ev = 0;
        ent = '0;
        if (v) model_byte(d, ev, ent);
        room = (sz < DEPTH) || do_pop;
        if (do_pop) void'(mq.pop_front());
        if (ev && room) mq.push_back(ent);
        if (ev && !room) m_ovf = 1;
        else if (clr) m_ovf = 0;
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
        bus.evt_ready  = 1'b0;
        clr_ovf        = 1'b0;
        check_all();
    endtask

    task automatic send(input logic [7:0] d);
        step(1, d, 0, 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 4 * DEPTH && mq.size() > 0; k++) step(0, 8'h00, 1, 0);
        chk("drain_empty", bus.evt_count, 0);
    endtask

    function automatic logic [7:0] rnd_byte();
        int r;
        r = $urandom_range(0, 15);
        case (r)
            0, 1:    return 8'hE0;
            2, 3:    return 8'hF0;
            4:       return ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h12;
            5:       return 8'hAA;
            6:       return 8'hFA;
            7:       return 8'($urandom);
            default: return KMAP[$urandom_range(0, 7)][7:0];
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        clr_ovf = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'h00;
        bus.evt_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("rst_evt_data", bus.evt_data, 0);
        chk("rst_evt_index", bus.evt_index, 0);
        rst = 1'b0;

        // Plain make / break of key index 1
        send(8'h16);
        chk("t1_keys_make", key_down, 8'h02);
        chk("t1_head", bus.evt_data, 11'h416);
        chk("t1_index", bus.evt_index, 1);
        send(8'hF0);
        send(8'h16);
        chk("t1_keys_break", key_down, 8'h00);
        chk("t1_count", bus.evt_count, 2);
        drain();

        // Extended make/break and fake shift
        send(8'hE0); send(8'h75);
        chk("t2_keys_make", key_down, 8'h40);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("t2_keys_break", key_down, 8'h00);
        send(8'hE0); send(8'h12);
        chk("t2_count", bus.evt_count, 2);
        chk("t2_head", bus.evt_data, 11'h575);
        drain();

        // Pause sequence is swallowed
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        chk("t3_quiet", bus.evt_count, 0);
        send(8'h45);
        chk("t3_keys", key_down, 8'h01);
        chk("t3_head", bus.evt_data, 11'h445);
        send(8'hF0); send(8'h45);
        drain();

        // Fill, overflow, clear, simultaneous push/pop at full
        for (int k = 0; k < 9; k++) send(8'h1C);
        chk("t4_count_full", bus.evt_count, 8);
        chk("t4_ovf_set", overflow, 1);
        chk("t4_head", bus.evt_data, 11'h01C);
        step(0, 8'h00, 0, 1);
        chk("t4_ovf_clr", overflow, 0);
        step(1, 8'h1C, 1, 0);
        chk("t4_pushpop", bus.evt_count, 8);
        chk("t4_no_ovf", overflow, 0);
        drain();

        // BAT clears the held map without an event
        send(8'h5A); send(8'h29);
        chk("t5_keys", key_down, 8'h30);
        chk("t5_any", any_down, 1);
        send(8'hAA);
        chk("t5_bat", key_down, 8'h00);
        chk("t5_any_clr", any_down, 0);
        chk("t5_count", bus.evt_count, 2);
        drain();

        // Typematic repeats
        send(8'h5A); send(8'h5A); send(8'h5A);
`ifdef TYPEMATIC_FILTER_EN
        chk("t6_repeats", bus.evt_count, 1);
`else
        chk("t6_repeats", bus.evt_count, 3);
`endif
        send(8'hF0); send(8'h5A);
        chk("t6_keys", key_down, 8'h00);
        drain();

        // Reset in the middle of an extended sequence
        send(8'hE0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all();
        send(8'h75);
        chk("rst_mid_head", bus.evt_data, 11'h075);
        drain();

        // Random traffic
        for (int k = 0; k < 800; k++) begin
            step($urandom_range(0, 3) != 0, rnd_byte(), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
